// File: rtl/fifo_ctrl_param.sv
// FIFO controller for an external dual-port RAM of 2**AW words: pointers, occupancy,
// status flags, sticky error bits and read-group load pulses.
module fifo_ctrl_param #(
    parameter int AW     = 4,
    parameter int THRESH = 12,
    parameter int GRP_LG = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          rd,
    input  logic          err_clr,
    output logic          fifo_we,
    output logic          fifo_rd,
    output logic [AW-1:0] waddr,
    output logic [AW-1:0] raddr,
    output logic [AW:0]   count,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic          fifo_threshold,
    output logic          rptr_ld,
    output logic          overflow,
    output logic          underflow
);

    localparam logic [AW:0]   THR_CNT  = (AW+1)'(THRESH);
    localparam logic [AW:0]   ONE      = (AW+1)'(1);
    localparam logic [AW-1:0] GRP_MASK = AW'((1 << GRP_LG) - 1);

    logic [AW:0] wptr;
    logic [AW:0] rptr;

    // Flags depend only on registered state, so wr_en/rd never reach them combinationally.
    assign fifo_full      = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign fifo_empty     = (wptr == rptr);
    assign fifo_threshold = (count >= THR_CNT);

    assign fifo_we = wr_en & ~fifo_full;
    assign fifo_rd = rd & ~fifo_empty;
    assign waddr   = wptr[AW-1:0];
    assign raddr   = rptr[AW-1:0];
    assign rptr_ld = fifo_rd & ((raddr & GRP_MASK) == '0);

    // NOTE: registered state uses non-blocking assignments so every register samples
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (fifo_we) wptr <= wptr + ONE;
            if (fifo_rd) rptr <= rptr + ONE;

            case ({fifo_we, fifo_rd})
                2'b10:   count <= count + ONE;
                2'b01:   count <= count - ONE;
                default: count <= count;
            endcase

            // Set term wins over err_clr when both occur in the same cycle.
            overflow  <= (overflow  & ~err_clr) | (wr_en & fifo_full);
            underflow <= (underflow & ~err_clr) | (rd    & fifo_empty);
        end
    end

endmodule

// File: tb/tb_fifo_ctrl_param.sv
// Self-checking bench for fifo_ctrl_param: directed corner cases followed by randomized
// traffic, all compared against an occupancy/pointer model built from plain arithmetic.
module tb_fifo_ctrl_param;

    localparam int AW     = 4;
    localparam int THRESH = 12;
    localparam int GRP_LG = 3;
    localparam int DEPTH  = 1 << AW;
    localparam int PMOD   = 2 * DEPTH;
    localparam int GRP    = 1 << GRP_LG;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd = 1'b0;
    logic          err_clr = 1'b0;
    logic          fifo_we;
    logic          fifo_rd;
    logic [AW-1:0] waddr;
    logic [AW-1:0] raddr;
    logic [AW:0]   count;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_threshold;
    logic          rptr_ld;
    logic          overflow;
    logic          underflow;

    fifo_ctrl_param #(.AW(AW), .THRESH(THRESH), .GRP_LG(GRP_LG)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .rd(rd), .err_clr(err_clr),
        .fifo_we(fifo_we), .fifo_rd(fifo_rd), .waddr(waddr), .raddr(raddr),
        .count(count), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .fifo_threshold(fifo_threshold), .rptr_ld(rptr_ld),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total    = 0;

    // Reference model: words held, total writes/reads accepted (mod pointer range), sticky bits.
    int m_count = 0;
    int m_w     = 0;
    int m_r     = 0;
    bit m_ovf   = 0;
    bit m_unf   = 0;
    bit last_ld = 0;

    task automatic check(input string tag, input int actual, input int expected);
        total++;
        if (actual == expected) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", tag, actual, expected, $time);
    endtask

    task automatic model_reset();
        m_count = 0; m_w = 0; m_r = 0; m_ovf = 0; m_unf = 0;
    endtask

    task automatic check_all();
        bit acc_w, acc_r;
        acc_w = wr_en && (m_count < DEPTH);
        acc_r = rd && (m_count > 0);
        check("fifo_we",   int'(fifo_we),        int'(acc_w));
        check("fifo_rd",   int'(fifo_rd),        int'(acc_r));
        check("waddr",     int'(waddr),          m_w % DEPTH);
        check("raddr",     int'(raddr),          m_r % DEPTH);
        check("count",     int'(count),          m_count);
        check("full",      int'(fifo_full),      int'(m_count == DEPTH));
        check("empty",     int'(fifo_empty),     int'(m_count == 0));
        check("threshold", int'(fifo_threshold), int'(m_count >= THRESH));
        check("rptr_ld",   int'(rptr_ld),        int'(acc_r && (m_r % GRP == 0)));
        check("overflow",  int'(overflow),       int'(m_ovf));
        check("underflow", int'(underflow),      int'(m_unf));
    endtask

    // One clock: drive on the falling edge, check mid-low-phase, advance model after the rise.
    task automatic cycle(input bit w, input bit r, input bit c);
        bit acc_w, acc_r;
        @(negedge clk);
        wr_en = w; rd = r; err_clr = c;
        #1;
        check_all();
        last_ld = rptr_ld;
        @(posedge clk);
        #1;
        acc_w = w && (m_count < DEPTH);
        acc_r = r && (m_count > 0);
        m_ovf = (m_ovf && !c) || (w && m_count == DEPTH);
        m_unf = (m_unf && !c) || (r && m_count == 0);
        m_count = m_count + int'(acc_w) - int'(acc_r);
        m_w = (m_w + int'(acc_w)) % PMOD;
        m_r = (m_r + int'(acc_r)) % PMOD;
    endtask

    // Asynchronous reset asserted between edges while traffic inputs are active.
    task automatic mid_reset();
        @(negedge clk);
        wr_en = 1'b1; rd = 1'b1; err_clr = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(fifo_empty), 1);
        check("rst_full",  int'(fifo_full), 0);
        check("rst_thr",   int'(fifo_threshold), 0);
        check("rst_ovf",   int'(overflow), 0);
        check("rst_unf",   int'(underflow), 0);
        check("rst_waddr", int'(waddr), 0);
        check("rst_raddr", int'(raddr), 0);
        @(posedge clk);
        #1;
        check("rst_hold_count", int'(count), 0);
        check("rst_hold_waddr", int'(waddr), 0);
        @(negedge clk);
        wr_en = 1'b0; rd = 1'b0;
        rst = 1'b1;
    endtask

    initial begin
        int wr_pct;
        #12 rst = 1'b1;
        cycle(0, 0, 0);

        // Fill to full, then attempt a 17th write.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(1, 0, 0);
            check("thr_fill", int'(fifo_threshold), int'(i + 1 >= THRESH));
        end
        check("fill_count", int'(count), DEPTH);
        check("fill_full", int'(fifo_full), 1);
        cycle(1, 0, 0);
        check("ovf_set", int'(overflow), 1);
        check("ovf_waddr", int'(waddr), 0);

        // Drain with load pulses on the 1st and 9th reads, then read while empty.
        for (int i = 0; i < DEPTH; i++) begin
            cycle(0, 1, 0);
            check("ld_pulse", int'(last_ld), int'(i % GRP == 0));
        end
        check("drain_empty", int'(fifo_empty), 1);
        cycle(0, 1, 0);
        check("unf_set", int'(underflow), 1);
        cycle(0, 0, 1);
        check("unf_clr", int'(underflow), 0);
        check("ovf_clr", int'(overflow), 0);

        // Simultaneous traffic at count 5, long enough for the pointers to wrap.
        for (int i = 0; i < 5; i++) cycle(1, 0, 0);
        for (int i = 0; i < 40; i++) cycle(1, 1, 0);
        check("simul_count", int'(count), 5);
        check("simul_waddr", int'(waddr), (DEPTH + 45) % DEPTH);

        // Full with simultaneous request: read wins, write blocked.
        for (int i = 0; i < DEPTH - 5; i++) cycle(1, 0, 0);
        cycle(1, 1, 0);
        check("edge_full_count", int'(count), DEPTH - 1);
        check("edge_full_ovf", int'(overflow), 1);
        for (int i = 0; i < DEPTH - 1; i++) cycle(0, 1, 1);
        cycle(1, 1, 0);
        check("edge_empty_count", int'(count), 1);
        check("edge_empty_unf", int'(underflow), 1);

        mid_reset();

        // Randomized traffic with phases biased toward full, empty and balanced occupancy.
        for (int i = 0; i < 10000; i++) begin
            case ((i / 700) % 3)
                0:       wr_pct = 80;
                1:       wr_pct = 20;
                default: wr_pct = 50;
            endcase
            cycle($urandom_range(99) < wr_pct,
                  $urandom_range(99) < (100 - wr_pct),
                  $urandom_range(99) < 5);
            if (i == 5000) mid_reset();
        end

        mid_reset();
        cycle(0, 0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
